// File: rtl/acc_shift_add.sv
// Accumulator for a shift-and-add multiplier: parallel load, add-in, or logical shift right.
// Optional macro ACC_CARRY_EN keeps the add carry in register C, exposed on Cout, and shifts it back in.
module acc_shift_add #(
  parameter int WIDTH = 9
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load,
  input  logic             Ad,
  input  logic             Sh,
  input  logic [WIDTH-1:0] Entradas,
  output logic [WIDTH-1:0] Saidas
`ifdef ACC_CARRY_EN
  ,
  output logic             Cout
`endif
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum;
  logic             shift_in;

`ifdef ACC_CARRY_EN
  logic carry;
  logic c;

  assign {carry, sum} = {1'b0, acc} + {1'b0, Entradas};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      c <= 1'b0;
    end else if (Load) begin
      c <= 1'b0;
    end else if (Ad) begin
      c <= carry;
    end else if (Sh) begin
      c <= 1'b0;
    end
  end

  assign shift_in = c;
  assign Cout     = c;
`else
  assign sum      = acc + Entradas;
  assign shift_in = 1'b0;
`endif

  // Fixed priority Load > Ad > Sh; with no command the register holds.
  always_ff @(posedge Clk or negedge Rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Rst_n) begin
      acc <= '0;
    end else if (Load) begin
      acc <= Entradas;
    end else if (Ad) begin
      acc <= sum;
    end else if (Sh) begin
      acc <= {shift_in, acc[WIDTH-1:1]};
    end
  end

  assign Saidas = acc;

endmodule

// File: tb/tb_acc_shift_add.sv
// Self-checking bench for acc_shift_add: directed literal sequences plus a randomized run
// compared every cycle against an arithmetic model of the accumulator.
module tb_acc_shift_add;
  localparam int W = 9;

  logic         Clk;
  logic         Rst_n;
  logic         Load;
  logic         Ad;
  logic         Sh;
  logic [W-1:0] Entradas;
  logic [W-1:0] Saidas;
`ifdef ACC_CARRY_EN
  logic         Cout;
`endif

  acc_shift_add #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Load     (Load),
    .Ad       (Ad),
    .Sh       (Sh),
    .Entradas (Entradas),
    .Saidas   (Saidas)
`ifdef ACC_CARRY_EN
    ,
    .Cout     (Cout)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Model: accumulator value and carry as plain integers.
  int m_acc = 0;
  int m_c = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_update(input logic l, input logic a, input logic s, input int d);
    int total;
    if (l) begin
      m_acc = d;
      m_c = 0;
    end else if (a) begin
      total = m_acc + d;
`ifdef ACC_CARRY_EN
      m_c = total / (1 << W);
`endif
      m_acc = total % (1 << W);
    end else if (s) begin
      m_acc = (m_acc + m_c * (1 << W)) / 2;
      m_c = 0;
    end
  endtask

  // Inputs change just after a falling edge; the model advances with the rising edge.
  task automatic step(input logic l, input logic a, input logic s, input logic [W-1:0] d);
    Load = l;
    Ad = a;
    Sh = s;
    Entradas = d;
    @(posedge Clk);
    if (Rst_n) model_update(l, a, s, int'(d));
    @(negedge Clk);
    #1;
    Load = 1'b0;
    Ad = 1'b0;
    Sh = 1'b0;
  endtask

  task automatic async_reset();
    Rst_n = 1'b0;
    m_acc = 0;
    m_c = 0;
  endtask

  always @(negedge Clk) begin
    check("cycle_saidas", int'(Saidas), m_acc);
`ifdef ACC_CARRY_EN
    check("cycle_cout", int'(Cout), m_c);
`endif
  end

  initial begin
    Rst_n = 1'b1;
    Load = 1'b0;
    Ad = 1'b0;
    Sh = 1'b0;
    Entradas = '0;
    #1;
    async_reset();
    @(negedge Clk);
    #1;

    // Commands are ignored while reset is held.
    step(1'b1, 1'b0, 1'b0, 9'd7);
    check("reset_hold_load", int'(Saidas), 0);
    step(1'b0, 1'b1, 1'b1, 9'd7);
    check("reset_hold_add", int'(Saidas), 0);
    Rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 9'd7);
    check("reset_release_idle", int'(Saidas), 0);

    step(1'b1, 1'b0, 1'b0, 9'd7);
    check("chain_load7", int'(Saidas), 7);
    step(1'b0, 1'b0, 1'b1, 9'd0);
    check("chain_sh", int'(Saidas), 3);
    step(1'b0, 1'b1, 1'b0, 9'd496);
    check("chain_ad496", int'(Saidas), 499);
    step(1'b0, 1'b0, 1'b0, 9'd100);
    check("chain_idle", int'(Saidas), 499);

    step(1'b1, 1'b0, 1'b0, 9'd15);
    check("op2_load15", int'(Saidas), 15);
    step(1'b0, 1'b0, 1'b0, 9'd3);
    check("op2_idle1", int'(Saidas), 15);
    step(1'b0, 1'b0, 1'b1, 9'd3);
    check("op2_sh", int'(Saidas), 7);
    step(1'b0, 1'b0, 1'b0, 9'd3);
    check("op2_idle2", int'(Saidas), 7);
    step(1'b0, 1'b1, 1'b0, 9'd496);
    check("op2_ad496", int'(Saidas), 503);
    step(1'b0, 1'b0, 1'b0, 9'd0);
    check("op2_idle3", int'(Saidas), 503);

    step(1'b1, 1'b1, 1'b1, 9'd5);
    check("prio_load_wins", int'(Saidas), 5);
    step(1'b0, 1'b1, 1'b1, 9'd2);
    check("prio_add_wins", int'(Saidas), 7);

    step(1'b1, 1'b0, 1'b0, 9'd496);
    check("wrap_load496", int'(Saidas), 496);
    step(1'b0, 1'b1, 1'b0, 9'd496);
    check("wrap_ad496", int'(Saidas), 480);
`ifdef ACC_CARRY_EN
    check("carry_set", int'(Cout), 1);
    step(1'b0, 1'b0, 1'b1, 9'd0);
    check("carry_sh", int'(Saidas), 496);
    check("carry_sh_cout", int'(Cout), 0);
    step(1'b0, 1'b1, 1'b0, 9'd496);
    check("carry_set2", int'(Cout), 1);
    step(1'b1, 1'b0, 1'b0, 9'd1);
    check("carry_load_clears", int'(Cout), 0);
`else
    step(1'b0, 1'b0, 1'b1, 9'd0);
    check("wrap_sh", int'(Saidas), 240);
`endif

    // All ones shifts down to zero in WIDTH steps.
    step(1'b1, 1'b0, 1'b0, 9'h1FF);
    for (int i = 0; i < W; i++) step(1'b0, 1'b0, 1'b1, 9'h1FF);
    check("ones_shift_to_zero", int'(Saidas), 0);

    // Asynchronous reset mid-sequence clears before the next rising edge.
    step(1'b1, 1'b0, 1'b0, 9'd300);
    check("pre_async_load", int'(Saidas), 300);
    async_reset();
    #1;
    check("async_reset_immediate", int'(Saidas), 0);
    step(1'b0, 1'b1, 1'b0, 9'd9);
    Rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 9'd9);
    check("after_async_idle", int'(Saidas), 0);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        async_reset();
        step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 1)), W'($urandom_range(0, (1 << W) - 1)));
        Rst_n = 1'b1;
      end else begin
        step(logic'(r < 15), logic'($urandom_range(0, 2) == 0),
             logic'($urandom_range(0, 1)), W'($urandom_range(0, (1 << W) - 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
